// File: rtl/combine_n.sv
// N-way request join with a clocked C-element phase bit, supporting four-phase
// (return-to-zero) and two-phase (transition) handshakes.

module combine_lane #(
    parameter bit TWO_PHASE = 1'b0
) (
    input  logic r,
    input  logic ph,
    input  logic arr,
    input  logic a_o,
    output logic differ,
    output logic viol
);
    assign differ = r ^ ph;

    // Four-phase only: withdrawing a request before the join fires, or
    // dropping it before the consumer has acknowledged.
    assign viol = !TWO_PHASE && !r && ((!ph && arr) || (ph && !a_o));
endmodule

module combine_n #(
    parameter int   N         = 2,
    parameter int   W         = 8,
    parameter logic RVAL      = 1'b0,
    parameter bit   TWO_PHASE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   r_i,
    output logic [N-1:0]   a_i,
    input  logic [N*W-1:0] d_i,
    output logic           r_o,
    input  logic           a_o,
    output logic [N*W-1:0] d_o,
    output logic [N-1:0]   arrived,
    output logic           err
);
    logic         ph;
    logic [N-1:0] differ;
    logic [N-1:0] viol;
    logic         fire;
    logic         load;

    for (genvar k = 0; k < N; k++) begin : g_lane
        combine_lane #(.TWO_PHASE(TWO_PHASE)) u_lane (
            .r      (r_i[k]),
            .ph     (ph),
            .arr    (arrived[k]),
            .a_o    (a_o),
            .differ (differ[k]),
            .viol   (viol[k])
        );
    end

    // In both protocols the join fires when every request disagrees with ph:
    // four-phase all-1 with ph=0 / all-0 with ph=1, two-phase all toggled.
    assign fire = &differ;
    assign load = fire && (TWO_PHASE || !ph);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      <= RVAL;
            d_o     <= '0;
            arrived <= '0;
            err     <= 1'b0;
        end else begin
            if (fire) ph <= ~ph;
            if (load) d_o <= d_i;
            arrived <= fire ? '0 : differ;
            if (|viol) err <= 1'b1;
        end
    end

    assign r_o = ph;
    assign a_i = {N{a_o}};
endmodule

// File: doc/combine_n.md
COMBINE_N -- requirements
Module: combine_n

Interface
REQ-001 Parameter N, default 2: number of input channels joined; legal range 2..8.
REQ-002 Parameter W, default 8: data width per input channel; legal range 1..64.
REQ-003 Parameter RVAL, default 1'b0: reset value of r_o and of the internal phase.
REQ-004 Parameter TWO_PHASE, default 1'b0: 0 = four-phase (return-to-zero) protocol, 1 = two-phase (transition) protocol.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 r_i  input  N  per-channel request.
REQ-008 a_i  output  N  per-channel acknowledge.
REQ-009 d_i  input  N*W  per-channel data; channel k occupies bits [k*W +: W].
REQ-010 r_o  output  1  joined request, registered.
REQ-011 a_o  input  1  acknowledge from the consumer.
REQ-012 d_o  output  N*W  joined data, registered; same packing as d_i.
REQ-013 arrived  output  N  registered status; bit k set when channel k has presented its event for the current join.
REQ-014 err  output  1  registered, sticky protocol-violation flag.

Function
REQ-015 a_i[k] SHALL equal a_o for every k, combinationally; no per-channel acknowledge gating.
REQ-016 An internal phase bit ph SHALL hold the current value of r_o; r_o is driven from ph.
REQ-017 Four-phase: at each edge, if every r_i bit is 1 and ph=0, then ph<=1; if every r_i bit is 0 and ph=1, then ph<=0; otherwise ph holds (clocked C-element hysteresis).
REQ-018 Two-phase: at each edge, if every r_i[k] differs from ph, then ph<=~ph; otherwise ph holds.
REQ-019 Latency: r_o SHALL change on the same edge that samples the qualifying r_i condition, which is one clock after the last input arrives.
REQ-020 d_o SHALL load the full d_i on the edge where ph transitions 0->1 (four-phase) or on any ph toggle (two-phase); otherwise d_o holds.
REQ-021 arrived[k] SHALL be registered as (r_i[k] != ph) each edge; on the edge where ph toggles, arrived SHALL load all zeros.
REQ-022 Four-phase violation: while ph=0, channel k has arrived[k]=1 and r_i[k] samples 0 (request withdrawn before the join fires); err<=1.
REQ-023 Four-phase violation: while ph=1 and a_o=0, channel k has r_i[k] sampled 0 (request dropped before acknowledge); err<=1.
REQ-024 Two-phase mode SHALL never set err.
REQ-025 Once set, err SHALL remain 1 until reset; violations do not alter ph, d_o or arrived behaviour.
REQ-026 For N=2 and TWO_PHASE=0, r_o SHALL match a reset-able Muller C-element of r_i[0] and r_i[1], delayed by one clock.
REQ-027 Simultaneous arrival of all channels in one cycle SHALL fire the join on that edge; arrival order is irrelevant.

Reset
REQ-028 While rst=1: ph=r_o=RVAL, d_o=0, arrived=0, err=0, asynchronously, regardless of clk.
REQ-029 Reset asserted mid-handshake SHALL abandon the join; after release, the first edge evaluates r_i against ph=RVAL.
REQ-030 a_i SHALL follow a_o during reset, with no reset override.

Verification
REQ-031 N=2, W=8, four-phase: r_i=01, then 11 with d_i=0xA55A -> r_o=1 and d_o=0xA55A one edge after 11; arrived=01 before the join, 00 after.
REQ-032 Four-phase return: after REQ-031, a_o=1, r_i=10, then 00 -> r_o stays 1 until r_i=00, falls on the next edge; d_o holds 0xA55A; a_i=11 throughout a_o=1.
REQ-033 N=4, two-phase, RVAL=0: channels toggle to 1 in order 0,2,1,3 -> ph toggles to 1 only on the edge after channel 3; a second round toggling all to 0 -> r_o returns to 0; err stays 0.
REQ-034 Four-phase withdrawal: r_i=01, then 00 while r_o=0 -> err=1 on that edge and remains 1 across later valid joins until rst.
REQ-035 Reset mid-operation: r_o=1 with RVAL=0, assert rst asynchronously between edges -> r_o, d_o, arrived and err clear immediately; after release with r_i=11 -> r_o=1 on the first edge.
REQ-036 RVAL=1, four-phase, N=3: after reset r_o=1; r_i=000 -> r_o=0 one edge later; r_i=111 -> r_o=1 and d_o captured.
